cas_result_fifo: RTL and testbench

- Downstream stage of the estimation system. Consumes the registered Is / alpha results and their one-cycle ready flags (REG_THETA_I / REG_THETA_V, exported as ACK_THETA_IF / ACK_THETA_VF).
- Pairs the two values and buffers the pairs in a small FIFO for the host or telemetry reader.
- Returns the ACK_CAS_I / ACK_CAS_V handshakes that let the estimator control FSM advance. When the FIFO is full it withholds them, which back-pressures the estimator.

---
 rtl/cas_result_fifo_pkg.sv | 30 +++
 rtl/cas_pair_ram.sv | 71 +++++++
 rtl/cas_result_fifo.sv | 186 ++++++++++++++++++
 tb/tb_cas_result_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cas_result_fifo_pkg.sv
// Shared definitions for the CAS result FIFO: default sizes, FSM encoding
// and the packed pair-word layout {tag, alpha, is} (is in the low bits).
package cas_result_fifo_pkg;

  localparam int unsigned N_DEFAULT          = 32;
  localparam int unsigned DEPTH_LOG2_DEFAULT = 3;
  localparam int unsigned TAG_W_DEFAULT      = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHalf   = 2'd1,
    StCommit = 2'd2
  } cas_state_e;

  // Pair word layout, LSB first: is, then alpha, then the optional tag.
  localparam int unsigned PairIsLsb = 0;

  function automatic int unsigned pair_alpha_lsb(input int unsigned n);
    return PairIsLsb + n;
  endfunction

  function automatic int unsigned pair_tag_lsb(input int unsigned n);
    return PairIsLsb + 2 * n;
  endfunction

  function automatic int unsigned pair_width(input int unsigned n, input int unsigned tag_w);
    return 2 * n + tag_w;
  endfunction

endpackage

// File: rtl/cas_pair_ram.sv
// Dual-pointer register-file FIFO holding packed result pairs. Keeps its own
// occupancy count; full/empty are registered alongside the count.
module cas_pair_ram #(
  parameter int unsigned W          = 64,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [W-1:0]        wr_data,
  input  logic                rd_en,
  output logic [W-1:0]        rd_data,
  output logic [DEPTH_LOG2:0] count,
  output logic                empty,
  output logic                full
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DepthCnt = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [W-1:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    full_q, empty_q;
  logic                    push, pop;

  // Writes into a full FIFO and reads from an empty one are dropped.
  assign push = wr_en & ~full_q;
  assign pop  = rd_en & ~empty_q;

  // Storage array; no reset needed, the head is only observed when non-empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally modulo the depth; flags track the new count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      count_q <= count_d;
      full_q  <= (count_d == DepthCnt);
      empty_q <= (count_d == '0);
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = empty_q;
  assign full    = full_q;

endmodule

// File: rtl/cas_result_fifo.sv
// cas_result_fifo: pairs registered Is / alpha results, acknowledges each half
// back to the estimator and buffers completed pairs for the reader.
// Optional sequence tag per pair is enabled by defining CAS_TAG_EN.
module cas_result_fifo
  import cas_result_fifo_pkg::*;
#(
  parameter int unsigned N          = N_DEFAULT,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
  parameter int unsigned TAG_W      = TAG_W_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N-1:0]          RESULT_IS,
  input  logic [N-1:0]          RESULT_ALPHA,
  input  logic                  ACK_THETA_IF,
  input  logic                  ACK_THETA_VF,
  output logic                  ACK_CAS_I,
  output logic                  ACK_CAS_V,
  input  logic                  RD_EN,
  output logic [N-1:0]          OUT_IS,
  output logic [N-1:0]          OUT_ALPHA,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [DEPTH_LOG2:0]   COUNT
`ifdef CAS_TAG_EN
  ,
  output logic [TAG_W-1:0]      OUT_TAG
`endif
);

`ifdef CAS_TAG_EN
  localparam int unsigned TagStore = TAG_W;
`else
  // Tag width is accepted but nothing is stored without the tag feature.
  localparam int unsigned TagStore = 0 * TAG_W;
`endif
  localparam int unsigned PairW    = pair_width(N, TagStore);
  localparam int unsigned AlphaLsb = pair_alpha_lsb(N);

  cas_state_e state_q, state_d;

  logic          flag_i_q, flag_v_q;
  logic [N-1:0]  hold_is_q, hold_alpha_q;
  logic          have_i_q, have_v_q, have_i_d, have_v_d;
  logic          acked_i_q, acked_v_q, acked_i_d, acked_v_d;
  logic          ovf_sticky_q, ovf_sticky_d;
  logic          ack_i, ack_v;
  logic          commit;
  logic [PairW-1:0] wr_data, rd_data;

  assign commit = (state_q == StCommit);

  // Acks are withheld while the FIFO has no free slot.
  assign ack_i = have_i_q & ~acked_i_q & ~FULL;
  assign ack_v = have_v_q & ~acked_v_q & ~FULL;
  assign ACK_CAS_I = ack_i;
  assign ACK_CAS_V = ack_v;

  // Register the ready pulses; the result word is valid in the following cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flag_i_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      flag_i_q <= ACK_THETA_IF;
      flag_v_q <= ACK_THETA_VF;
    end
  end

  // Hold registers capture the result word in the registered-flag cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_is_q    <= '0;
      hold_alpha_q <= '0;
    end else begin
      if (flag_i_q) hold_is_q    <= RESULT_IS;
      if (flag_v_q) hold_alpha_q <= RESULT_ALPHA;
    end
  end

  // Half bookkeeping: commit clears, a fresh capture in the same cycle wins.
  always_comb begin
    have_i_d     = have_i_q;
    have_v_d     = have_v_q;
    acked_i_d    = acked_i_q;
    acked_v_d    = acked_v_q;
    ovf_sticky_d = ovf_sticky_q;
    if (commit) begin
      have_i_d  = 1'b0;
      have_v_d  = 1'b0;
      acked_i_d = 1'b0;
      acked_v_d = 1'b0;
    end
    if (ack_i) acked_i_d = 1'b1;
    if (ack_v) acked_v_d = 1'b1;
    if (flag_i_q) begin
      if (have_i_q && !commit) ovf_sticky_d = 1'b1;
      have_i_d = 1'b1;
    end
    if (flag_v_q) begin
      if (have_v_q && !commit) ovf_sticky_d = 1'b1;
      have_v_d = 1'b1;
    end
  end

  // Half-state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      have_i_q     <= 1'b0;
      have_v_q     <= 1'b0;
      acked_i_q    <= 1'b0;
      acked_v_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      have_i_q     <= have_i_d;
      have_v_q     <= have_v_d;
      acked_i_q    <= acked_i_d;
      acked_v_q    <= acked_v_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  // Pairing FSM next state; a half captured during COMMIT restarts from IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (flag_i_q || flag_v_q || have_i_q || have_v_q) state_d = StHalf;
      end
      StHalf: begin
        if (have_i_q && have_v_q && acked_i_q && acked_v_q) state_d = StCommit;
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CAS_TAG_EN
  localparam int unsigned TagLsb = pair_tag_lsb(N);

  logic [TAG_W-1:0] tag_q;

  // Sequence tag advances once per committed pair and wraps to zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_q <= '0;
    end else if (commit) begin
      tag_q <= tag_q + TAG_W'(1);
    end
  end

  assign wr_data = {tag_q, hold_alpha_q, hold_is_q};
  assign OUT_TAG = EMPTY ? '0 : rd_data[TagLsb +: TAG_W];
`else
  assign wr_data = {hold_alpha_q, hold_is_q};
`endif

  cas_pair_ram #(
    .W          (PairW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (commit),
    .wr_data (wr_data),
    .rd_en   (RD_EN),
    .rd_data (rd_data),
    .count   (COUNT),
    .empty   (EMPTY),
    .full    (FULL)
  );

  // Head pair is forced to zero while empty so stale entries never show.
  assign OUT_IS    = EMPTY ? '0 : rd_data[PairIsLsb +: N];
  assign OUT_ALPHA = EMPTY ? '0 : rd_data[AlphaLsb +: N];

endmodule

// File: tb/tb_cas_result_fifo.sv
// Self-checking bench for cas_result_fifo: directed scenarios plus random
// push/pop traffic compared against a queue-based model of stored pairs.
module tb_cas_result_fifo;

  localparam int unsigned N  = 32;
  localparam int unsigned DL = 3;
  localparam int unsigned TW = 16;

  typedef struct {
    logic [31:0] is_w;
    logic [31:0] al_w;
    logic [15:0] tag;
  } pair_t;

  logic        CLK, RST;
  logic [31:0] RESULT_IS, RESULT_ALPHA;
  logic        ACK_THETA_IF, ACK_THETA_VF;
  logic        ACK_CAS_I, ACK_CAS_V;
  logic        RD_EN;
  logic [31:0] OUT_IS, OUT_ALPHA;
  logic        EMPTY, FULL;
  logic [3:0]  COUNT;
`ifdef CAS_TAG_EN
  logic [15:0] OUT_TAG;
`endif

  int    checks   = 0;
  int    failures = 0;
  pair_t model_q[$];
  int    tag_ctr  = 0;

  cas_result_fifo #(
    .N          (N),
    .DEPTH_LOG2 (DL),
    .TAG_W      (TW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RESULT_IS    (RESULT_IS),
    .RESULT_ALPHA (RESULT_ALPHA),
    .ACK_THETA_IF (ACK_THETA_IF),
    .ACK_THETA_VF (ACK_THETA_VF),
    .ACK_CAS_I    (ACK_CAS_I),
    .ACK_CAS_V    (ACK_CAS_V),
    .RD_EN        (RD_EN),
    .OUT_IS       (OUT_IS),
    .OUT_ALPHA    (OUT_ALPHA),
    .EMPTY        (EMPTY),
    .FULL         (FULL),
    .COUNT        (COUNT)
`ifdef CAS_TAG_EN
    ,
    .OUT_TAG      (OUT_TAG)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [31:0] is_w, input logic [31:0] al_w);
    pair_t p;
    p.is_w = is_w;
    p.al_w = al_w;
    p.tag  = tag_ctr[15:0];
    model_q.push_back(p);
    tag_ctr++;
  endtask

  task automatic check_model(input string where);
    check({where, "_count"}, COUNT, model_q.size());
    check({where, "_empty"}, EMPTY, model_q.size() == 0);
    check({where, "_full"},  FULL,  model_q.size() == 8);
    if (model_q.size() > 0) begin
      check({where, "_out_is"},    OUT_IS,    model_q[0].is_w);
      check({where, "_out_alpha"}, OUT_ALPHA, model_q[0].al_w);
`ifdef CAS_TAG_EN
      check({where, "_out_tag"},   OUT_TAG,   model_q[0].tag);
`endif
    end else begin
      check({where, "_out_is_zero"}, OUT_IS, 0);
    end
  endtask

  // One-cycle ready pulse with its result word held valid afterwards.
  task automatic pulse(input bit is_v, input logic [31:0] val);
    if (is_v) begin
      RESULT_ALPHA = val;
      ACK_THETA_VF = 1'b1;
    end else begin
      RESULT_IS    = val;
      ACK_THETA_IF = 1'b1;
    end
    tick();
    ACK_THETA_IF = 1'b0;
    ACK_THETA_VF = 1'b0;
  endtask

  task automatic wait_ack(input bit is_v, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      seen = is_v ? ACK_CAS_V : ACK_CAS_I;
    end
    check(tag, seen, 1);
  endtask

  task automatic push_pair(input logic [31:0] is_w, input logic [31:0] al_w,
                           input bit v_first, input int gap);
    pulse(v_first, v_first ? al_w : is_w);
    wait_ack(v_first, "push_ack_first");
    repeat (gap) tick();
    pulse(!v_first, v_first ? is_w : al_w);
    wait_ack(!v_first, "push_ack_second");
    repeat (4) tick();
    model_push(is_w, al_w);
  endtask

  task automatic pop_one();
    pair_t p;
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    if (model_q.size() > 0) p = model_q.pop_front();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    model_q.delete();
    tag_ctr = 0;
    tick();
  endtask

  initial begin
    bit          seen;
    int          op;
    logic [31:0] a, b;

    RST          = 1'b1;
    RESULT_IS    = '0;
    RESULT_ALPHA = '0;
    ACK_THETA_IF = 1'b0;
    ACK_THETA_VF = 1'b0;
    RD_EN        = 1'b0;
    tick();
    tick();

    // Reset values.
    check("rst_count", COUNT, 0);
    check("rst_empty", EMPTY, 1);
    check("rst_full",  FULL,  0);
    check("rst_out_is", OUT_IS, 0);
    check("rst_out_alpha", OUT_ALPHA, 0);
    check("rst_ack_i", ACK_CAS_I, 0);
    check("rst_ack_v", ACK_CAS_V, 0);
`ifdef CAS_TAG_EN
    check("rst_out_tag", OUT_TAG, 0);
`endif
    RST = 1'b0;
    tick();

    // Basic pair: IF at cycle 0, VF at cycle 5, acks two cycles after each.
    RESULT_IS    = 32'h3A83126F;
    ACK_THETA_IF = 1'b1;
    tick();
    ACK_THETA_IF = 1'b0;
    check("basic_ack_i_c1", ACK_CAS_I, 0);
    tick();
    check("basic_ack_i_c2", ACK_CAS_I, 1);
    tick();
    check("basic_ack_i_c3", ACK_CAS_I, 0);
    tick();
    tick();
    RESULT_ALPHA = 32'h41200000;
    ACK_THETA_VF = 1'b1;
    tick();
    ACK_THETA_VF = 1'b0;
    check("basic_ack_v_c6", ACK_CAS_V, 0);
    tick();
    check("basic_ack_v_c7", ACK_CAS_V, 1);
    repeat (4) tick();
    model_push(32'h3A83126F, 32'h41200000);
    check_model("basic");
    pop_one();
    check_model("basic_pop");

    // Simultaneous flags: both acks in the same cycle, one pair stored.
    RESULT_IS    = 32'hC0490FDB;
    RESULT_ALPHA = 32'h3F800000;
    ACK_THETA_IF = 1'b1;
    ACK_THETA_VF = 1'b1;
    tick();
    ACK_THETA_IF = 1'b0;
    ACK_THETA_VF = 1'b0;
    tick();
    check("simul_ack_i", ACK_CAS_I, 1);
    check("simul_ack_v", ACK_CAS_V, 1);
    repeat (4) tick();
    model_push(32'hC0490FDB, 32'h3F800000);
    check_model("simul");
    pop_one();

    // Read while empty is ignored.
    RD_EN = 1'b1;
    repeat (4) tick();
    RD_EN = 1'b0;
    check_model("empty_read");

    // Three pairs, then a push and a pop landing on the same edge.
    for (int i = 0; i < 3; i++) push_pair($urandom, $urandom, 1'b0, i);
    check_model("three");
    a = $urandom;
    b = $urandom;
    pulse(1'b0, a);
    wait_ack(1'b0, "same_ack_i");
    pulse(1'b1, b);
    wait_ack(1'b1, "same_ack_v");
    tick();
    tick();
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    pop_one_model: begin
      pair_t p;
      p = model_q.pop_front();
    end
    model_push(a, b);
    check_model("same_cycle");

    // Overwrite of a held half sets the sticky flag and the newer word wins.
    a = $urandom;
    pulse(1'b0, 32'h11111111);
    wait_ack(1'b0, "ovf_ack_i");
    pulse(1'b0, a);
    repeat (3) tick();
    check("ovf_sticky", dut.ovf_sticky_q, 1);
    b = $urandom;
    pulse(1'b1, b);
    wait_ack(1'b1, "ovf_ack_v");
    repeat (4) tick();
    model_push(a, b);
    check_model("ovf_pair");

    // Full back-pressure.
    while (model_q.size() > 0) pop_one();
    check_model("drained");
    for (int i = 0; i < 8; i++) push_pair($urandom, $urandom, i[0], 1);
    check_model("full8");
    a = $urandom;
    pulse(1'b0, a);
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen |= ACK_CAS_I;
    end
    check("full_no_ack", seen, 0);
    pop_one();
    seen = ACK_CAS_I;
    for (int i = 0; i < 2 && !seen; i++) begin
      tick();
      seen = ACK_CAS_I;
    end
    check("full_ack_after_pop", seen, 1);
    b = $urandom;
    pulse(1'b1, b);
    wait_ack(1'b1, "full_ack_v");
    repeat (4) tick();
    model_push(a, b);
    check_model("full_refill");

    // Reset mid-pair: outputs clear at once, the captured half is dropped.
    pulse(1'b0, $urandom);
    tick();
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_count", COUNT, 0);
    check("async_rst_empty", EMPTY, 1);
    check("async_rst_full",  FULL,  0);
    check("async_rst_out_is", OUT_IS, 0);
    check("async_rst_ack_i", ACK_CAS_I, 0);
    tick();
    RST = 1'b0;
    model_q.delete();
    tag_ctr = 0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= ACK_CAS_V;
    end
    check("rst_no_ack_v", seen, 0);
    push_pair($urandom, $urandom, 1'b1, 2);
    check("rst_wr_index0", dut.u_ram.wr_ptr_q, 1);
    check_model("rst_pair");

    // Ten pairs interleaved with reads; tags follow 0..9 in read order.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push_pair($urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 3));
`ifdef CAS_TAG_EN
      check("tag_seq", OUT_TAG, i);
`endif
      check_model("tag_loop");
      pop_one();
    end

    // Random traffic against the queue model.
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 2);
      if (op != 0 && model_q.size() < 8) begin
        push_pair($urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 3));
      end else begin
        pop_one();
      end
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
